// File: rtl/dm_cache_pkg.sv
// Shared widths, FSM state type, line layout and address-field helpers for
// the direct-mapped read-only cache.
package dm_cache_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned INDEX_W = 8;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned LINES   = 1 << INDEX_W;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StRefill,
        StResp,
        StFlush
    } state_e;

    // Ascending word order puts word0 in the most significant slot.
    typedef logic [0:WORDS-1][DATA_W-1:0] line_data_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        line_data_t       data;
    } line_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_W+3:4];
    endfunction

    function automatic logic [OFF_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Line storage: combinational read, synchronous full-line write, per-index
// valid clear, and asynchronous clear of every valid bit on reset.
module dm_cache_array
    import dm_cache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output line_t              rd_line_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  line_t              wr_line_i,
    input  logic               clr_en_i,
    input  logic [INDEX_W-1:0] clr_idx_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    line_data_t       data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (clr_en_i) begin
            valid_d[clr_idx_i] = 1'b0;
        end
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_line_i.valid;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset; the valid bit gates every use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_line_i.tag;
            data_mem[wr_idx_i] <= wr_line_i.data;
        end
    end

    always_comb begin
        rd_line_o.valid = valid_q[rd_idx_i];
        rd_line_o.tag   = tag_mem[rd_idx_i];
        rd_line_o.data  = data_mem[rd_idx_i];
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: tag lookup, line refill from
// backing memory, sequential invalidate-all and saturating hit/miss counters.
module dm_cache_ctrl
    import dm_cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_hit_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    line_data_t         buf_q, buf_d;
    logic [DATA_W-1:0]  resp_data_q, resp_data_d;
    logic               resp_hit_q, resp_hit_d;
    logic [INDEX_W-1:0] flush_idx_q, flush_idx_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    line_t              rd_line;
    line_t              wr_line;
    line_data_t         refill_data;
    logic               hit;
    logic               take_req;
    logic               beat_take;
    logic               refill_done;

    assign hit         = rd_line.valid && (rd_line.tag == get_tag(addr_q));
    assign take_req    = (state_q == StIdle) && !flush_i && req_valid_i;
    assign beat_take   = (state_q == StRefill) && mem_rvalid_i;
    assign refill_done = beat_take && (beat_q == LAST_BEAT);

    // Buffer with the current beat merged in, so the final beat can be
    // written and answered in the same cycle.
    always_comb begin
        refill_data         = buf_q;
        refill_data[beat_q] = mem_rdata_i;
    end

    always_comb begin
        wr_line.valid = 1'b1;
        wr_line.tag   = get_tag(addr_q);
        wr_line.data  = refill_data;
    end

    dm_cache_array u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx_i  (get_index(addr_q)),
        .rd_line_o (rd_line),
        .wr_en_i   (refill_done),
        .wr_idx_i  (get_index(addr_q)),
        .wr_line_i (wr_line),
        .clr_en_i  (state_q == StFlush),
        .clr_idx_i (flush_idx_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (flush_i) begin
                    state_d = StFlush;
                end else if (req_valid_i) begin
                    state_d = StLookup;
                end
            end
            StLookup:  state_d = hit ? StResp : StMissReq;
            StMissReq: if (mem_req_ready_i) state_d = StRefill;
            StRefill:  if (refill_done) state_d = StResp;
            StResp:    state_d = StIdle;
            StFlush:   if (flush_idx_q == '1) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        beat_d      = '0;
        buf_d       = buf_q;
        resp_data_d = resp_data_q;
        resp_hit_d  = resp_hit_q;
        flush_idx_d = flush_idx_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (take_req) begin
            addr_d = req_addr_i;
        end
        if (state_q == StLookup) begin
            resp_hit_d = hit;
            if (hit) begin
                resp_data_d = rd_line.data[get_word(addr_q)];
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
        if (state_q == StRefill) begin
            beat_d = beat_q;
            if (beat_take) begin
                beat_d = beat_q + 1'b1;
                buf_d  = refill_data;
            end
            if (refill_done) begin
                resp_data_d = refill_data[get_word(addr_q)];
                resp_hit_d  = 1'b0;
            end
        end
        if (state_q == StFlush) begin
            flush_idx_d = flush_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            beat_q      <= '0;
            buf_q       <= '0;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
            flush_idx_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            buf_q       <= buf_d;
            resp_data_q <= resp_data_d;
            resp_hit_q  <= resp_hit_d;
            flush_idx_q <= flush_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Reset leaves the FSM in idle, so ready is also gated by rst_i.
    always_comb begin
        req_ready_o     = !rst_i && (state_q == StIdle) && !flush_i;
        busy_o          = (state_q != StIdle);
        resp_valid_o    = (state_q == StResp);
        resp_data_o     = resp_valid_o ? resp_data_q : '0;
        resp_hit_o      = resp_valid_o && resp_hit_q;
        mem_req_valid_o = (state_q == StMissReq);
        mem_req_addr_o  = mem_req_valid_o ? {get_tag(addr_q), get_index(addr_q), 4'b0000} : '0;
        hit_cnt_o       = hit_cnt_q;
        miss_cnt_o      = miss_cnt_q;
    end

    logic unused_byte_off;
    assign unused_byte_off = ^addr_q[1:0];

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: miss/refill, hit latency, eviction,
// stalled memory, flush and mid-refill reset.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [15:0] req_addr_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_hit_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [15:0] mem_req_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        flush_i;
    logic        busy_o;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    dm_cache_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .resp_valid_o    (resp_valid_o),
        .resp_data_o     (resp_data_o),
        .resp_hit_o      (resp_hit_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .flush_i         (flush_i),
        .busy_o          (busy_o),
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full miss transaction: ready stalled rdy_dly cycles, gap idle cycles between beats.
    task automatic do_miss(input logic [15:0] addr, input logic [31:0] base,
                           input int rdy_dly, input int gap, input logic [31:0] exp);
        tick();
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        @(negedge clk);
        chk("miss_req_ready", {31'b0, req_ready_o}, 32'd1);
        tick();
        req_valid_i  = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lookup_busy", {31'b0, busy_o}, 32'd1);
        chk("lookup_no_memreq", {31'b0, mem_req_valid_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        for (int d = 0; d < rdy_dly; d++) begin
            @(negedge clk);
            chk("memreq_valid_stall", {31'b0, mem_req_valid_o}, 32'd1);
            chk("memreq_addr_stall", {16'b0, mem_req_addr_o}, {16'b0, addr & 16'hFFF0});
            tick();
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        chk("memreq_valid", {31'b0, mem_req_valid_o}, 32'd1);
        chk("memreq_addr", {16'b0, mem_req_addr_o}, {16'b0, addr & 16'hFFF0});
        tick();
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = base + k;
            @(negedge clk);
            chk("refill_no_resp", {31'b0, resp_valid_o}, 32'd0);
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_no_resp", {31'b0, resp_valid_o}, 32'd0);
                    tick();
                end
            end
        end
        @(negedge clk);
        chk("miss_resp_valid", {31'b0, resp_valid_o}, 32'd1);
        chk("miss_resp_data", resp_data_o, exp);
        chk("miss_resp_hit", {31'b0, resp_hit_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("miss_resp_pulse", {31'b0, resp_valid_o}, 32'd0);
        chk("miss_resp_data0", resp_data_o, 32'd0);
        chk("miss_idle", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic do_hit(input logic [15:0] addr, input logic [31:0] exp);
        tick();
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        @(negedge clk);
        chk("hit_req_ready", {31'b0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("hit_n1_no_resp", {31'b0, resp_valid_o}, 32'd0);
        chk("hit_n1_no_memreq", {31'b0, mem_req_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("hit_resp_valid", {31'b0, resp_valid_o}, 32'd1);
        chk("hit_resp_data", resp_data_o, exp);
        chk("hit_resp_hit", {31'b0, resp_hit_o}, 32'd1);
        chk("hit_no_memreq", {31'b0, mem_req_valid_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("hit_resp_pulse", {31'b0, resp_valid_o}, 32'd0);
    endtask

    initial begin
        int n_busy;
        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_addr_i      = 16'h0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = 32'h0;
        flush_i         = 1'b0;
        #2;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_resp", {31'b0, resp_valid_o}, 32'd0);
        chk("rst_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
        chk("rst_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Cold miss, then hit on the same line, then eviction by a new tag.
        do_miss(16'h1230, 32'hA000_0000, 0, 0, 32'hA000_0000);
        chk("cnt_miss1", {16'b0, miss_cnt_o}, 32'd1);
        do_hit(16'h123C, 32'hA000_0003);
        chk("cnt_hit1", {16'b0, hit_cnt_o}, 32'd1);
        do_miss(16'h2230, 32'hB000_0000, 0, 0, 32'hB000_0000);
        chk("cnt_miss2", {16'b0, miss_cnt_o}, 32'd2);
        do_hit(16'h2234, 32'hB000_0001);

        // Evicted line misses again, with a stalled memory and spaced beats.
        do_miss(16'h1238, 32'hC000_0000, 5, 2, 32'hC000_0002);
        chk("cnt_miss3", {16'b0, miss_cnt_o}, 32'd3);
        do_hit(16'h1231, 32'hC000_0000);
        chk("cnt_hit3", {16'b0, hit_cnt_o}, 32'd3);

        // Flush: 256 busy cycles, ready held low.
        tick();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 16'h1230;
        @(negedge clk);
        chk("flush_ready", {31'b0, req_ready_o}, 32'd0);
        tick();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        n_busy      = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_o) n_busy++;
            if (i == 100) chk("flush_mid_ready", {31'b0, req_ready_o}, 32'd0);
        end
        chk("flush_busy_cycles", n_busy, 32'd256);
        chk("flush_no_lookup", {16'b0, miss_cnt_o}, 32'd3);
        do_miss(16'h123C, 32'hD000_0000, 0, 0, 32'hD000_0003);
        chk("cnt_miss4", {16'b0, miss_cnt_o}, 32'd4);

        // Reset after two refill beats.
        tick();
        req_valid_i = 1'b1;
        req_addr_i  = 16'h4560;
        tick();
        req_valid_i = 1'b0;
        tick();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b1;
        mem_rdata_i     = 32'h7000_0000;
        tick();
        mem_rdata_i = 32'h7000_0001;
        tick();
        mem_rdata_i = 32'h7000_0002;
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready_o}, 32'd0);
        chk("mid_rst_memreq", {31'b0, mem_req_valid_o}, 32'd0);
        chk("mid_rst_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
        chk("mid_rst_miss_cnt", {16'b0, miss_cnt_o}, 32'd0);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        tick();
        tick();
        rst_i = 1'b0;
        do_miss(16'h4560, 32'hE000_0000, 0, 1, 32'hE000_0000);
        chk("post_rst_miss_cnt", {16'b0, miss_cnt_o}, 32'd1);
        chk("post_rst_hit_cnt", {16'b0, hit_cnt_o}, 32'd0);
        do_hit(16'h456C, 32'hE000_0003);
        chk("post_rst_hit_cnt1", {16'b0, hit_cnt_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
